// File: rtl/dmem_access_unit.sv
// Data-memory sequencer: one load/store at a time against a 64-bit word memory.
// Sub-word stores use read-modify-write; completion is signalled by a single resp_valid pulse.
module dmem_access_unit #(
    parameter int DATA_W       = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_splice,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_misaligned,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP} state_t;

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              write_p0;
    logic [1:0]        splice_p0;
    logic [2:0]        off_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              accept;
    logic              misaligned;
    logic              rd_done;

    function automatic logic is_misaligned(input logic [1:0] splice, input logic [2:0] off);
        case (splice)
            2'b00:   return off != 3'd0;
            2'b01:   return off[1:0] != 2'd0;
            2'b10:   return off[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] extract_load(input logic [DATA_W-1:0] word,
                                                       input logic [1:0] splice,
                                                       input logic [2:0] off);
        logic [DATA_W-1:0] sh;
        sh = word >> {off, 3'b000};
        case (splice)
            2'b00:   return word;
            2'b01:   return {{(DATA_W-32){sh[31]}}, sh[31:0]};
            2'b10:   return {{(DATA_W-16){sh[15]}}, sh[15:0]};
            default: return {{(DATA_W-8){1'b0}}, sh[7:0]};
        endcase
    endfunction

    // Replace only the addressed byte lanes; every other lane keeps the word read back.
    function automatic logic [DATA_W-1:0] merge_store(input logic [DATA_W-1:0] word,
                                                      input logic [DATA_W-1:0] wdata,
                                                      input logic [1:0] splice,
                                                      input logic [2:0] off);
        logic [7:0]        lanes;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] sh;
        case (splice)
            2'b01:   lanes = 8'h0F;
            2'b10:   lanes = 8'h03;
            default: lanes = 8'h01;
        endcase
        lanes = lanes << off;
        mask  = '0;
        for (int k = 0; k < 8; k++) begin
            mask[8*k +: 8] = {8{lanes[k]}};
        end
        sh = wdata << {off, 3'b000};
        return (word & ~mask) | (sh & mask);
    endfunction

    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign misaligned = is_misaligned(req_splice, req_addr[2:0]);
    assign mem_rd     = (state == RD_ISSUE);
    assign mem_wr     = (state == WR_ISSUE);
    assign resp_valid = (state == RESP);
    assign rd_done    = (state == RD_WAIT) && (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned)                           state_nxt = RESP;
                    else if (req_write && req_splice == 2'b00) state_nxt = WR_ISSUE;
                    else                                      state_nxt = RD_ISSUE;
                end
            end
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT:  if (cnt == CNT_LAST) state_nxt = write_p0 ? WR_ISSUE : RESP;
            WR_ISSUE: state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            write_p0        <= 1'b0;
            splice_p0       <= 2'b00;
            off_p0          <= 3'd0;
            wdata_p0        <= '0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == RD_ISSUE)     cnt <= '0;
            else if (state == RD_WAIT) cnt <= cnt + 1'b1;

            // Request capture stage
            if (accept) begin
                write_p0  <= req_write;
                splice_p0 <= req_splice;
                off_p0    <= req_addr[2:0];
                wdata_p0  <= req_wdata;
                mem_addr  <= {req_addr[DATA_W-1:3], 3'b000};
                if (req_write && req_splice == 2'b00) mem_wdata <= req_wdata;
            end

            // Read-return stage
            if (rd_done && write_p0) mem_wdata <= merge_store(mem_rdata, wdata_p0, splice_p0, off_p0);

            // Response stage: result only changes when a new response is about to be presented
            if (state_nxt == RESP && state != RESP) begin
                resp_misaligned <= (state == IDLE);
                resp_rdata      <= (rd_done && !write_p0) ?
                                   extract_load(mem_rdata, splice_p0, off_p0) : '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: directed loads/stores on a READ_LATENCY=1 instance,
// back-to-back loads on a READ_LATENCY=3 instance sharing the same memory model.
module tb_dmem_access_unit;

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
        int          due;
        int          n_rd;
        int          n_wr;
        logic [63:0] maddr;
        logic [63:0] wd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_load;
    logic        req_valid1, req_valid3, req_write;
    logic [1:0]  req_splice;
    logic [63:0] req_addr, req_wdata;

    logic        rdy1, rv1, mis1, mrd1, mwr1;
    logic [63:0] rdata1, maddr1, mwd1, mrdata1;
    logic        rdy3, rv3, mis3, mrd3, mwr3;
    logic [63:0] rdata3, maddr3, mwd3, mrdata3;

    logic [63:0] mem [0:7];
    logic [63:0] rq1, rq3a, rq3b, rq3c;

    dmem_access_unit #(.DATA_W(64), .READ_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(rdy1),
        .req_write(req_write), .req_splice(req_splice), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_rdata(rdata1), .resp_misaligned(mis1),
        .mem_addr(maddr1), .mem_rd(mrd1), .mem_wr(mwr1), .mem_wdata(mwd1), .mem_rdata(mrdata1)
    );

    dmem_access_unit #(.DATA_W(64), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(rdy3),
        .req_write(req_write), .req_splice(req_splice), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv3), .resp_rdata(rdata3), .resp_misaligned(mis3),
        .mem_addr(maddr3), .mem_rd(mrd3), .mem_wr(mwr3), .mem_wdata(mwd3), .mem_rdata(mrdata3)
    );

    // Word memory with a registered read path of depth 1 and depth 3
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 8; i++) mem[i] <= 64'h0;
            mem[2] <= 64'h8877665544332211;
        end else if (mwr1) begin
            mem[maddr1[5:3]] <= mwd1;
        end
        rq1  <= mem[maddr1[5:3]];
        rq3a <= mem[maddr3[5:3]];
        rq3b <= rq3a;
        rq3c <= rq3b;
    end
    assign mrdata1 = rq1;
    assign mrdata3 = rq3c;

    int   n_chk = 0, n_fail = 0;
    int   cyc = 0;
    exp_t q1[$], q3[$];
    exp_t nx1, nx3;
    int   acc_cnt1 = 0, acc_cnt3 = 0, acc3_a = 0, acc3_b = 0;
    int   rd_cnt1 = 0, wr_cnt1 = 0, wr_total1 = 0, busy_ready3 = 0;
    logic [63:0] last_addr1 = '0, last_wd1 = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: records accepts at the clock edge, checks responses and memory traffic mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!reset && req_valid1 && rdy1) begin
                e = nx1; e.due = cyc + nx1.due; q1.push_back(e);
                rd_cnt1 = 0; wr_cnt1 = 0; acc_cnt1++;
            end
            if (!reset && req_valid3 && rdy3) begin
                e = nx3; e.due = cyc + nx3.due; q3.push_back(e);
                if (acc_cnt3 == 0) acc3_a = cyc; else acc3_b = cyc;
                acc_cnt3++;
            end
            cyc++;
            @(negedge clk);
            if (mrd1) begin rd_cnt1++; last_addr1 = maddr1; end
            if (mwr1) begin wr_cnt1++; wr_total1++; last_addr1 = maddr1; last_wd1 = mwd1; end
            if (q3.size() != 0 && rdy3) busy_ready3++;
            if (rv1) begin
                if (q1.size() == 0) chk("spurious_resp1", rv1, 1'b0);
                else begin
                    e = q1.pop_front();
                    chk("resp_rdata", rdata1, e.rdata);
                    chk("resp_misaligned", mis1, e.mis);
                    chk("resp_latency_cycle", cyc, e.due);
                    chk("mem_rd_count", rd_cnt1, e.n_rd);
                    chk("mem_wr_count", wr_cnt1, e.n_wr);
                    if (e.n_rd + e.n_wr > 0) chk("mem_addr", last_addr1, e.maddr);
                    if (e.n_wr > 0) chk("mem_wdata", last_wd1, e.wd);
                end
            end
            if (rv3) begin
                if (q3.size() == 0) chk("spurious_resp3", rv3, 1'b0);
                else begin
                    e = q3.pop_front();
                    chk("rl3_resp_rdata", rdata3, e.rdata);
                    chk("rl3_resp_misaligned", mis3, e.mis);
                    chk("rl3_latency_cycle", cyc, e.due);
                end
            end
        end
    end

    task automatic wait_accept1(input int n0);
        int ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_cnt1 != n0) begin ok = 1; break; end
        end
        if (ok == 0) chk("accept_timeout", 0, 1);
    endtask

    task automatic req1(input logic w, input logic [1:0] sp, input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic mis, input int lat,
                        input int nrd, input int nwr, input logic [63:0] exp_wd);
        int n0;
        int ok = 0;
        nx1 = '{rdata: exp_rd, mis: mis, due: lat, n_rd: nrd, n_wr: nwr,
                maddr: {a[63:3], 3'b000}, wd: exp_wd};
        @(negedge clk);
        req_write = w; req_splice = sp; req_addr = a; req_wdata = wd;
        n0 = acc_cnt1;
        req_valid1 = 1'b1;
        wait_accept1(n0);
        req_valid1 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (q1.size() == 0) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok == 0) begin
            chk("resp_timeout", 0, 1);
            q1.delete();
        end
    endtask

    initial begin
        int n0, w0;
        int ok;
        reset = 1'b1; mem_load = 1'b1;
        req_valid1 = 1'b0; req_valid3 = 1'b0;
        req_write = 1'b0; req_splice = 2'b00; req_addr = '0; req_wdata = '0;
        nx1 = '{rdata: '0, mis: 1'b0, due: 0, n_rd: 0, n_wr: 0, maddr: '0, wd: '0};
        nx3 = nx1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", rdy1, 1'b1);
        chk("rst_resp_valid", rv1, 1'b0);
        chk("rst_mem_rd_wr", {mrd1, mwr1}, 2'b00);
        chk("rst_resp_rdata", rdata1, 64'h0);
        chk("rst_rl3_req_ready", rdy3, 1'b1);
        @(negedge clk);
        reset = 1'b0; mem_load = 1'b0;

        // Loads, sub-word and full stores, misaligned faults (READ_LATENCY=1)
        req1(0, 2'b01, 64'h14, 64'h0, 64'hFFFFFFFF88776655, 0, 3, 1, 0, 64'h0);
        req1(0, 2'b11, 64'h17, 64'h0, 64'h0000000000000088, 0, 3, 1, 0, 64'h0);
        req1(0, 2'b10, 64'h16, 64'h0, 64'hFFFFFFFFFFFF8877, 0, 3, 1, 0, 64'h0);
        req1(1, 2'b11, 64'h13, 64'hAB, 64'h0, 0, 4, 1, 1, 64'h88776655AB332211);
        req1(1, 2'b00, 64'h18, 64'h0123456789ABCDEF, 64'h0, 0, 2, 0, 1, 64'h0123456789ABCDEF);
        req1(1, 2'b01, 64'h1C, 64'hDEADBEEFCAFEF00D, 64'h0, 0, 4, 1, 1, 64'hCAFEF00D89ABCDEF);
        req1(0, 2'b00, 64'h18, 64'h0, 64'hCAFEF00D89ABCDEF, 0, 3, 1, 0, 64'h0);
        req1(0, 2'b01, 64'h10, 64'h0, 64'hFFFFFFFFAB332211, 0, 3, 1, 0, 64'h0);
        req1(0, 2'b01, 64'h12, 64'h0, 64'h0, 1, 1, 0, 0, 64'h0);
        req1(1, 2'b10, 64'h11, 64'h1234, 64'h0, 1, 1, 0, 0, 64'h0);
        req1(0, 2'b00, 64'h19, 64'h0, 64'h0, 1, 1, 0, 0, 64'h0);
        req1(0, 2'b11, 64'h1E, 64'h0, 64'h00000000000000FE, 0, 3, 1, 0, 64'h0);

        // Reset while an sb sits in RD_WAIT
        nx1 = '{rdata: '0, mis: 1'b0, due: 4, n_rd: 1, n_wr: 1, maddr: 64'h10, wd: '0};
        @(negedge clk);
        req_write = 1'b1; req_splice = 2'b11; req_addr = 64'h13; req_wdata = 64'hCD;
        n0 = acc_cnt1;
        req_valid1 = 1'b1;
        wait_accept1(n0);
        req_valid1 = 1'b0;
        @(negedge clk);
        w0 = wr_total1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        q1.delete();
        chk("rstmid_req_ready", rdy1, 1'b1);
        chk("rstmid_resp_valid", rv1, 1'b0);
        chk("rstmid_resp_rdata", rdata1, 64'h0);
        chk("rstmid_resp_misaligned", mis1, 1'b0);
        chk("rstmid_mem_rd_wr", {mrd1, mwr1}, 2'b00);
        chk("rstmid_mem_addr", maddr1, 64'h0);
        chk("rstmid_mem_wdata", mwd1, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("rstmid_no_mem_wr", wr_total1, w0);
        chk("rstmid_mem_word", mem[2], 64'h88776655AB332211);
        req1(0, 2'b01, 64'h14, 64'h0, 64'hFFFFFFFF88776655, 0, 3, 1, 0, 64'h0);

        // READ_LATENCY=3, req_valid held high across two loads
        nx3 = '{rdata: 64'hFFFFFFFF88776655, mis: 1'b0, due: 5, n_rd: 1, n_wr: 0, maddr: 64'h10, wd: '0};
        @(negedge clk);
        req_write = 1'b0; req_splice = 2'b01; req_addr = 64'h14; req_wdata = '0;
        req_valid3 = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_cnt3 == 1) begin ok = 1; break; end
        end
        if (ok == 0) chk("rl3_accept1_timeout", 0, 1);
        nx3 = '{rdata: 64'hFFFFFFFF89ABCDEF, mis: 1'b0, due: 5, n_rd: 1, n_wr: 0, maddr: 64'h18, wd: '0};
        req_addr = 64'h18;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_cnt3 == 2) begin ok = 1; break; end
        end
        if (ok == 0) chk("rl3_accept2_timeout", 0, 1);
        req_valid3 = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (q3.size() == 0) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok == 0) chk("rl3_resp_timeout", 0, 1);
        chk("rl3_accept_spacing", acc3_b - acc3_a, 6);
        chk("rl3_ready_while_busy", busy_ready3, 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
